// File: rtl/cruce_n_vias.sv
`default_nettype none
// ============================================================================
//  Module   : cruce_n_vias
//  Purpose  : N-approach intersection controller with demand-driven green
//             extension, skipping of idle approaches and an all-red
//             pedestrian phase.
//  Ports    : clk          - single clock, rising edge
//             reset        - synchronous, active-low reset
//             enb          - advance enable (0 freezes the state machine)
//             sensor       - vehicle present on approach i (level)
//             peatonal_req - pedestrian request on approach i (pulse/level)
//             semaforo     - head i at [2i+1:2i]: 00 red, 01 yellow, 10 green
//             peatonal_ok  - pedestrian walk for approach i
//             via_activa   - index of the current or last-served approach
//  Revision : 1.0 - initial release
// ============================================================================
module cruce_n_vias #(
    parameter int N_VIAS      = 4,
    parameter int T_VERDE     = 4,
    parameter int T_VERDE_MAX = 8,
    parameter int T_AMARILLO  = 2,
    parameter int T_ROJO      = 1,
    parameter int T_PEATON    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enb,
    input  logic [N_VIAS-1:0]         sensor,
    input  logic [N_VIAS-1:0]         peatonal_req,
    output logic [2*N_VIAS-1:0]       semaforo,
    output logic [N_VIAS-1:0]         peatonal_ok,
    output logic [$clog2(N_VIAS)-1:0] via_activa
);

    localparam int C_VIA_W = $clog2(N_VIAS);

    // Counter is sized to the longest phase.
    localparam int C_T_A   = (T_VERDE_MAX > T_AMARILLO) ? T_VERDE_MAX : T_AMARILLO;
    localparam int C_T_B   = (T_ROJO > T_PEATON) ? T_ROJO : T_PEATON;
    localparam int C_T_MAX = (C_T_A > C_T_B) ? C_T_A : C_T_B;
    localparam int C_CNT_W = $clog2(C_T_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_FIN_VERDE_MIN = C_CNT_W'(T_VERDE - 1);
    localparam logic [C_CNT_W-1:0] C_FIN_VERDE_MAX = C_CNT_W'(T_VERDE_MAX - 1);
    localparam logic [C_CNT_W-1:0] C_FIN_AMARILLO  = C_CNT_W'(T_AMARILLO - 1);
    localparam logic [C_CNT_W-1:0] C_FIN_ROJO      = C_CNT_W'(T_ROJO - 1);
    localparam logic [C_CNT_W-1:0] C_FIN_PEATON    = C_CNT_W'(T_PEATON - 1);

    localparam logic [1:0] C_ST_TODO_ROJO = 2'd0;
    localparam logic [1:0] C_ST_VERDE     = 2'd1;
    localparam logic [1:0] C_ST_AMARILLO  = 2'd2;
    localparam logic [1:0] C_ST_PEATON    = 2'd3;

    logic [1:0]           r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_VIA_W-1:0]   r_via;
    logic [N_VIAS-1:0]    r_sensor;
    logic [N_VIAS-1:0]    r_ped_pend;
    logic [N_VIAS-1:0]    r_snap;

    logic [1:0]           w_state_nxt;
    logic [C_VIA_W-1:0]   w_via_nxt;
    logic [C_VIA_W-1:0]   w_via_sig;
    logic [N_VIAS-1:0]    w_sensor_otras;
    logic                 w_ped_any;
    logic                 w_dem;
    logic                 w_salto;
    logic                 w_entra_peaton;
    logic [N_VIAS-1:0]    w_snap_nxt;
    logic [N_VIAS-1:0]    w_ped_clr;
    logic [2*N_VIAS-1:0]  w_sem_nxt;
    logic [N_VIAS-1:0]    w_ok_nxt;

    // ------------------------------------------------------------------
    // Demand and next-approach selection (all from registered inputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_sensor_otras = '0;
        for (int i = 0; i < N_VIAS; i++) begin
            w_sensor_otras[i] = r_sensor[i] & (C_VIA_W'(i) != r_via);
        end
    end

    assign w_ped_any = |r_ped_pend;
    assign w_dem     = (|w_sensor_otras) | w_ped_any;

    // Walk offsets from the farthest down to the nearest so the closest
    // approach with a waiting vehicle wins; offset N_VIAS is the current
    // approach itself, the last resort before the plain +1 fallback.
    always_comb begin
        w_via_sig = C_VIA_W'((int'(r_via) + 1) % N_VIAS);
        for (int k = N_VIAS; k >= 1; k--) begin
            if (r_sensor[C_VIA_W'((int'(r_via) + k) % N_VIAS)]) begin
                w_via_sig = C_VIA_W'((int'(r_via) + k) % N_VIAS);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_via_nxt   = r_via;
        if (enb) begin
            case (r_state)
                C_ST_TODO_ROJO: begin
                    if (r_cnt == C_FIN_ROJO) begin
                        if (w_ped_any) begin
                            w_state_nxt = C_ST_PEATON;
                        end else begin
                            w_state_nxt = C_ST_VERDE;
                            w_via_nxt   = w_via_sig;
                        end
                    end
                end
                C_ST_VERDE: begin
                    if (((r_cnt >= C_FIN_VERDE_MIN) && w_dem) ||
                        (r_cnt == C_FIN_VERDE_MAX)) begin
                        w_state_nxt = C_ST_AMARILLO;
                    end
                end
                C_ST_AMARILLO: begin
                    if (r_cnt == C_FIN_AMARILLO) begin
                        w_state_nxt = C_ST_TODO_ROJO;
                    end
                end
                C_ST_PEATON: begin
                    if (r_cnt == C_FIN_PEATON) begin
                        w_state_nxt = C_ST_VERDE;
                        w_via_nxt   = w_via_sig;
                    end
                end
                default: w_state_nxt = C_ST_TODO_ROJO;
            endcase
        end
    end

    assign w_salto        = (w_state_nxt != r_state);
    assign w_entra_peaton = w_salto && (w_state_nxt == C_ST_PEATON);
    assign w_snap_nxt     = w_entra_peaton ? r_ped_pend : r_snap;

    // The served bits are dropped from the pending latch at phase entry
    // rather than at exit: the walk output comes from the snapshot, so the
    // observable behaviour is the same, and any request arriving while the
    // phase runs (including on its exit edge) is kept for the next phase.
    assign w_ped_clr = w_entra_peaton ? r_ped_pend : '0;

    // ------------------------------------------------------------------
    // Output logic, computed from the next state so the outputs can be
    // registered and line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_sem_nxt = '0;
        w_ok_nxt  = '0;
        for (int i = 0; i < N_VIAS; i++) begin
            if (C_VIA_W'(i) == w_via_nxt) begin
                if (w_state_nxt == C_ST_VERDE) begin
                    w_sem_nxt[2*i +: 2] = 2'b10;
                end else if (w_state_nxt == C_ST_AMARILLO) begin
                    w_sem_nxt[2*i +: 2] = 2'b01;
                end
            end
        end
        if (w_state_nxt == C_ST_PEATON) begin
            w_ok_nxt = w_snap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // State register (frozen while enb=0)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= C_ST_TODO_ROJO;
            r_cnt       <= '0;
            r_via       <= C_VIA_W'(N_VIAS - 1);
            r_snap      <= '0;
            semaforo    <= '0;
            peatonal_ok <= '0;
        end else if (enb) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_salto ? '0 : r_cnt + 1'b1;
            r_via       <= w_via_nxt;
            r_snap      <= w_snap_nxt;
            semaforo    <= w_sem_nxt;
            peatonal_ok <= w_ok_nxt;
        end
    end

    // Input capture runs regardless of enb; a same-cycle set beats the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sensor   <= '0;
            r_ped_pend <= '0;
        end else begin
            r_sensor   <= sensor;
            r_ped_pend <= (r_ped_pend & ~w_ped_clr) | peatonal_req;
        end
    end

    assign via_activa = r_via;

endmodule
`default_nettype wire

// File: tb/tb_cruce_n_vias.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cruce_n_vias
//  Purpose  : Directed scoreboard bench for cruce_n_vias (N_VIAS=4).
//             Stimulus pushes the expected registered outputs after each
//             edge; a monitor pops and compares on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cruce_n_vias;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic [3:0] sensor;
    logic [3:0] peatonal_req;
    logic [7:0] semaforo;
    logic [3:0] peatonal_ok;
    logic [1:0] via_activa;

    typedef struct packed {
        logic [7:0] sem;
        logic [3:0] ok;
        logic [1:0] via;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] Y = 2'b01;

    always #5 clk = ~clk;

    cruce_n_vias #(
        .N_VIAS      (4),
        .T_VERDE     (4),
        .T_VERDE_MAX (8),
        .T_AMARILLO  (2),
        .T_ROJO      (1),
        .T_PEATON    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enb          (enb),
        .sensor       (sensor),
        .peatonal_req (peatonal_req),
        .semaforo     (semaforo),
        .peatonal_ok  (peatonal_ok),
        .via_activa   (via_activa)
    );

    // Head value v placed on approach h, all other heads red.
    function automatic logic [7:0] hd(input int h, input logic [1:0] v);
        logic [7:0] t;
        t = {6'b0, v};
        return t << (2 * h);
    endfunction

    // Drive n cycles of constant inputs; after each edge record the outputs
    // that edge must produce.
    task automatic run(input int n, input logic rst, input logic en,
                       input logic [3:0] sen, input logic [3:0] req,
                       input logic [7:0] sem, input logic [3:0] ok,
                       input logic [1:0] via);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            reset        = rst;
            enb          = en;
            sensor       = sen;
            peatonal_req = req;
            @(posedge clk);
            e.sem = sem;
            e.ok  = ok;
            e.via = via;
            exp_q.push_back(e);
            #1;
        end
    endtask

    // Monitor: compare whatever expectation is due.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (semaforo !== mon_e.sem || peatonal_ok !== mon_e.ok ||
                via_activa !== mon_e.via) begin
                failures++;
                $display("FAIL outputs#%0d t=%0t: got semaforo=%b peatonal_ok=%b via_activa=%0d, want semaforo=%b peatonal_ok=%b via_activa=%0d",
                         checks, $time, semaforo, peatonal_ok, via_activa,
                         mon_e.sem, mon_e.ok, mon_e.via);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        enb          = 1'b1;
        sensor       = 4'b0;
        peatonal_req = 4'b0;

        // 1) Idle rotation: every approach gets the full maximum green.
        run(1, 1'b0, 1'b1, 4'b0, 4'b0, 8'h00, 4'b0, 2'd3);
        run(8, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, G), 4'b0, 2'd0);
        run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, Y), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd0);
        for (int h = 1; h < 4; h++) begin
            run(8, 1'b1, 1'b1, 4'b0, 4'b0, hd(h, G), 4'b0, 2'(h));
            run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(h, Y), 4'b0, 2'(h));
            run(1, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'(h));
        end
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, G), 4'b0, 2'd0);

        // 2) Enable dropped for 5 cycles after the first yellow cycle.
        run(1, 1'b0, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd3);
        run(8, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, G), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, Y), 4'b0, 2'd0);
        run(5, 1'b1, 1'b0, 4'b0, 4'b0, hd(0, Y), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, Y), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd0);
        run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(1, G), 4'b0, 2'd1);

        // 3) Sensor on approach 2: short green, approach 1 skipped; then a
        //    reset mid-green of approach 2 with a fresh pedestrian request.
        run(1, 1'b0, 1'b1, 4'b0100, 4'b0, 8'h00,    4'b0, 2'd3);
        run(4, 1'b1, 1'b1, 4'b0100, 4'b0, hd(0, G), 4'b0, 2'd0);
        run(2, 1'b1, 1'b1, 4'b0100, 4'b0, hd(0, Y), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0100, 4'b0, 8'h00,    4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0100, 4'b0, hd(2, G), 4'b0, 2'd2);
        run(1, 1'b1, 1'b1, 4'b0100, 4'b0010, hd(2, G), 4'b0, 2'd2);
        run(1, 1'b0, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd3);
        run(8, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, G), 4'b0, 2'd0);
        run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, Y), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, hd(1, G), 4'b0, 2'd1);

        // 4) Pedestrian pulse during green 0, then a repeat request on the
        //    pedestrian-phase exit edge which must trigger a second phase.
        run(1, 1'b0, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd3);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, G), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b1000, hd(0, G), 4'b0, 2'd0);
        run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, G), 4'b0, 2'd0);
        run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(0, Y), 4'b0, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd0);
        run(3, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b1000, 2'd0);
        run(1, 1'b1, 1'b1, 4'b0, 4'b1000, hd(1, G), 4'b0, 2'd1);
        run(3, 1'b1, 1'b1, 4'b0, 4'b0, hd(1, G), 4'b0, 2'd1);
        run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(1, Y), 4'b0, 2'd1);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd1);
        run(3, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b1000, 2'd1);
        run(8, 1'b1, 1'b1, 4'b0, 4'b0, hd(2, G), 4'b0, 2'd2);
        run(2, 1'b1, 1'b1, 4'b0, 4'b0, hd(2, Y), 4'b0, 2'd2);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, 8'h00,    4'b0, 2'd2);
        run(1, 1'b1, 1'b1, 4'b0, 4'b0, hd(3, G), 4'b0, 2'd3);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cruce_n_vias.md
# cruce_n_vias

Parametrised intersection controller: the next generation of the two-way `semaforos` crossing. It drives N vehicle approaches, each with a 2-bit signal head, plus latched pedestrian requests per approach. It adds demand-based green extension, skipping of approaches with no waiting vehicles, and a dedicated all-red pedestrian phase. It sits directly under the crossing testbench/tester pair and replaces the fixed two-way controller.

## Interface

- `N_VIAS`, 4, number of approaches (2..8)
- `T_VERDE`, 4, minimum green cycles (>=1)
- `T_VERDE_MAX`, 8, maximum green cycles (>=T_VERDE)
- `T_AMARILLO`, 2, yellow cycles (>=1)
- `T_ROJO`, 1, all-red clearance cycles (>=1)
- `T_PEATON`, 3, pedestrian phase cycles (>=1)
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `enb`  in  1  advance enable; 0 freezes the state machine
- `sensor`  in  N_VIAS  vehicle present on approach i (level)
- `peatonal_req`  in  N_VIAS  pedestrian request on approach i (pulse or level)
- `semaforo`  out  2*N_VIAS  head i at [2i+1:2i]: 00 red, 01 yellow, 10 green, 11 never driven
- `peatonal_ok`  out  N_VIAS  pedestrian walk for approach i
- `via_activa`  out  clog2(N_VIAS)  index of the current or last-served approach

## Operation

- States: TODO_ROJO, VERDE, AMARILLO, PEATON. The cycle counter `cnt` is sized to the largest timing parameter and clears on every state change.
- Reset (`reset`=0 at a posedge, dominates `enb`):
  - state=TODO_ROJO, cnt=0, via_activa=N_VIAS-1, so the first green goes to approach 0.
  - All heads are 00, peatonal_ok=0, and the pedestrian latch `ped_pend` is cleared.
- `ped_pend[i]` sets on any cycle with `peatonal_req[i]`=1, independent of `enb`. If set and clear happen in the same cycle, set wins.
- Demand `dem` = (`sensor` with the bit for via_activa masked off) OR (`ped_pend` != 0).
- VERDE: head[via_activa]=10, all other heads 00.
  - Leave to AMARILLO at cnt==T_VERDE-1 if `dem`.
  - Otherwise leave on the first later cycle with `dem`, or at cnt==T_VERDE_MAX-1, whichever comes first.
- AMARILLO: head[via_activa]=01. After T_AMARILLO cycles, go to TODO_ROJO.
- TODO_ROJO: all heads 00. After T_ROJO cycles:
  - If ped_pend!=0, go to PEATON.
  - Otherwise go to VERDE with via_activa = next index after via_activa (mod N) whose sensor=1. If no sensor is set, use via_activa+1 mod N.
- PEATON: all heads 00 and peatonal_ok = snapshot of ped_pend taken at entry.
  - After T_PEATON cycles, clear the snapshot bits from ped_pend, drive peatonal_ok=0 and go to VERDE with the next-approach rule above.
  - Requests arriving during PEATON stay pending for the next pedestrian phase.
- `enb`=0: state, cnt, via_activa and outputs hold. Only ped_pend keeps capturing requests.
- Two approaches are never green or yellow at once. A green is always followed by yellow and then at least T_ROJO all-red cycles.

## Timing

- All outputs are registered. They change one edge after the state transition decision, and no combinational path runs from inputs to outputs.
- Each phase lasts exactly its parameter count of enabled cycles. Disabled cycles do not count.
- sensor and peatonal_req are sampled at the rising edge. A request seen at edge k is eligible for `dem` from cycle k+1.
- Reset mid-phase: heads go all 00 at the next edge. Then T_ROJO cycles of all-red, then approach 0 green.

## Test plan

Defaults for all scenarios: N_VIAS=4, T_VERDE=4, T_VERDE_MAX=8, T_AMARILLO=2, T_ROJO=1, T_PEATON=3.

- Reset, enb=1, no inputs -> heads 00 for 1 cycle, then approach 0 green for 8 cycles, yellow 2, all-red 1, approach 1 green 8; rotation 0,1,2,3,0.
- sensor=4'b0100 held from reset -> approach 0 green exactly 4 cycles, yellow 2, red 1, then approach 2 green (approach 1 skipped), via_activa=2.
- peatonal_req[3] one-cycle pulse during approach 0 green -> green ends at 4 cycles, yellow 2, red 1, then PEATON 3 cycles with peatonal_ok=4'b1000 and all heads 00, then approach 1 green.
- enb=0 for 5 cycles after the first yellow cycle -> semaforo holds 01 throughout, and yellow totals exactly 2 enabled cycles.
- peatonal_req[3]=1 on the PEATON exit edge -> ped_pend[3] stays 1, and the next TODO_ROJO enters PEATON again.
- reset=0 for one edge mid-green of approach 2 -> next edge all heads 00, peatonal_ok=0, ped_pend=0; then 1 red cycle and approach 0 green.
